// File: rtl/cvxif_compressed_arbiter.sv
// Shares one CV-X-IF compressed channel among decode lanes, lowest pending lane first.
// Latency: request 1 cycle after pending, result 1 cycle after handshake; stalls pending lanes until resolved.
module cvxif_compressed_arbiter #(
    parameter int NrPorts       = 2,
    parameter int XLEN          = 64,
    parameter int TimeoutCycles = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [XLEN-1:0]         hart_id_i,
    input  logic [NrPorts-1:0]      lane_valid_i,
    input  logic [NrPorts-1:0]      lane_illegal_i,
    input  logic [NrPorts*16-1:0]   lane_instr_i,
    input  logic [NrPorts-1:0]      lane_consume_i,
    output logic [NrPorts-1:0]      lane_stall_o,
    output logic [NrPorts-1:0]      lane_done_o,
    output logic [NrPorts-1:0]      lane_accept_o,
    output logic [NrPorts*32-1:0]   lane_instr_o,
    output logic                    x_valid_o,
    input  logic                    x_ready_i,
    output logic [15:0]             x_instr_o,
    output logic [XLEN-1:0]         x_hartid_o,
    input  logic                    x_accept_i,
    input  logic [31:0]             x_instr_i,
    output logic                    busy_o
);

    localparam int SW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CW-1:0] CntMax = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic {IDLE, REQ} state_e;

    state_e                   state_q, state_d;
    logic [NrPorts-1:0]       pending;
    logic [NrPorts-1:0]       done_q, accept_q;
    logic [NrPorts-1:0][31:0] result_q;
    logic [SW-1:0]            sel_q, sel_d, sel_cand;
    logic [15:0]              instr_q, instr_d, instr_cand;
    logic [XLEN-1:0]          hartid_q;
    logic [CW-1:0]            cnt_q;
    logic                     start, finish, hs_accept;

    assign pending      = lane_valid_i & lane_illegal_i & ~done_q;
    assign lane_stall_o = pending;
    assign lane_done_o  = done_q;
    assign lane_accept_o = accept_q;
    assign lane_instr_o = result_q;
    assign x_valid_o    = (state_q == REQ);
    assign x_instr_o    = instr_q;
    assign x_hartid_o   = (state_q == REQ) ? hartid_q : hart_id_i;
    assign busy_o       = (state_q != IDLE);
    assign hs_accept    = x_ready_i & x_accept_i;

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        sel_cand   = '0;
        instr_cand = '0;
        for (int i = NrPorts - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_cand   = SW'(i);
                instr_cand = lane_instr_i[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        instr_d = instr_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending && !flush_i) begin
                    state_d = REQ;
                    sel_d   = sel_cand;
                    instr_d = instr_cand;
                    start   = 1'b1;
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (x_ready_i) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else if (TimeoutCycles != 0 && cnt_q == CntMax) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            instr_q  <= '0;
            hartid_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            instr_q <= instr_d;
            if (start) hartid_q <= hart_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start || flush_i) begin
            cnt_q <= '0;
        end else if (state_q == REQ) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A timeout completes with ready low, so hs_accept stores a reject.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= '0;
            accept_q <= '0;
            result_q <= '0;
        end else begin
            for (int i = 0; i < NrPorts; i++) begin
                if (flush_i) begin
                    done_q[i]   <= 1'b0;
                    accept_q[i] <= 1'b0;
                    result_q[i] <= '0;
                end else if (finish && sel_q == SW'(i)) begin
                    done_q[i]   <= 1'b1;
                    accept_q[i] <= hs_accept;
                    result_q[i] <= hs_accept ? x_instr_i : 32'h0;
                end else if (lane_consume_i[i]) begin
                    done_q[i]   <= 1'b0;
                    accept_q[i] <= 1'b0;
                    result_q[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cvxif_compressed_arbiter.sv
// Directed vector bench for cvxif_compressed_arbiter (2 lanes, 4-cycle timeout).
module tb_cvxif_compressed_arbiter;

    localparam logic [63:0] HART = 64'h0000_0000_0000_abcd;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] hart_id_i = HART;
    logic [1:0]  lane_valid_i = '0, lane_illegal_i = '0, lane_consume_i = '0;
    logic [31:0] lane_instr_i = '0;
    logic [1:0]  lane_stall_o, lane_done_o, lane_accept_o;
    logic [63:0] lane_instr_o;
    logic        x_valid_o, x_ready_i = 1'b0, x_accept_i = 1'b0, busy_o;
    logic [15:0] x_instr_o;
    logic [63:0] x_hartid_o;
    logic [31:0] x_instr_i = '0;

    cvxif_compressed_arbiter #(.NrPorts(2), .XLEN(64), .TimeoutCycles(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .hart_id_i(hart_id_i),
        .lane_valid_i(lane_valid_i), .lane_illegal_i(lane_illegal_i),
        .lane_instr_i(lane_instr_i), .lane_consume_i(lane_consume_i),
        .lane_stall_o(lane_stall_o), .lane_done_o(lane_done_o),
        .lane_accept_o(lane_accept_o), .lane_instr_o(lane_instr_o),
        .x_valid_o(x_valid_o), .x_ready_i(x_ready_i), .x_instr_o(x_instr_o),
        .x_hartid_o(x_hartid_o), .x_accept_i(x_accept_i), .x_instr_i(x_instr_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  valid, ill;
        logic [15:0] i0, i1;
        logic [1:0]  cons;
        logic        flush, rdy, acc;
        logic [31:0] xi;
        logic [1:0]  e_stall, e_done, e_acc;
        logic        e_xv;
        logic [15:0] e_xio;
        logic        e_busy;
        logic [31:0] e_li0, e_li1;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   cur = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic v(input logic [1:0] valid, ill, input logic [15:0] i0, i1,
                     input logic [1:0] cons, input logic flush, rdy, acc, input logic [31:0] xi,
                     input logic [1:0] e_stall, e_done, e_acc, input logic e_xv,
                     input logic [15:0] e_xio, input logic e_busy, input logic [31:0] e_li0, e_li1);
        vec_t r;
        r.valid = valid; r.ill = ill; r.i0 = i0; r.i1 = i1; r.cons = cons;
        r.flush = flush; r.rdy = rdy; r.acc = acc; r.xi = xi;
        r.e_stall = e_stall; r.e_done = e_done; r.e_acc = e_acc; r.e_xv = e_xv;
        r.e_xio = e_xio; r.e_busy = e_busy; r.e_li0 = e_li0; r.e_li1 = e_li1;
        vecs.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        // valid ill  i0  i1  cons fl rdy acc xi | stall done acc xv xio busy li0 li1
        // Single lane0 offload, accepted
        v(2'b01,2'b01,16'h9002,0,0,0,0,0,0,                 2'b01,0,0,0,0,0,0,0);
        v(2'b01,2'b01,16'h9002,0,0,0,1,1,32'h00100073,      2'b01,0,0,1,16'h9002,1,0,0);
        v(2'b01,2'b01,16'h9002,0,2'b01,0,0,0,0,             0,2'b01,2'b01,0,0,0,32'h00100073,0);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0);
        // Both lanes illegal, ready always high
        v(2'b11,2'b11,16'h0001,16'h0002,0,0,1,1,32'h11111111, 2'b11,0,0,0,0,0,0,0);
        v(2'b11,2'b11,16'h0001,16'h0002,0,0,1,1,32'h11111111, 2'b11,0,0,1,16'h0001,1,0,0);
        v(2'b11,2'b11,16'h0001,16'h0002,0,0,1,1,32'h22222222, 2'b10,2'b01,2'b01,0,0,0,32'h11111111,0);
        v(2'b11,2'b11,16'h0001,16'h0002,0,0,1,1,32'h22222222, 2'b10,2'b01,2'b01,1,16'h0002,1,32'h11111111,0);
        v(2'b11,2'b11,16'h0001,16'h0002,2'b11,0,0,0,0,        0,2'b11,2'b11,0,0,0,32'h11111111,32'h22222222);
        v(0,0,0,0,0,0,0,0,0,                                  0,0,0,0,0,0,0,0);
        // Timeout: ready held low, response data must not be stored
        v(2'b01,2'b01,16'h1234,0,0,0,0,1,32'hdeadbeef,      2'b01,0,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++)
            v(2'b01,2'b01,16'h1234,0,0,0,0,1,32'hdeadbeef,  2'b01,0,0,1,16'h1234,1,0,0);
        v(2'b01,2'b01,16'h1234,0,2'b01,0,0,0,0,             0,2'b01,0,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0);
        // Flush in second REQ cycle of lane1 with ready high
        v(2'b11,2'b11,16'h0aaa,16'h0bbb,0,0,0,0,0,           2'b11,0,0,0,0,0,0,0);
        v(2'b11,2'b11,16'h0aaa,16'h0bbb,0,0,1,1,32'h33333333, 2'b11,0,0,1,16'h0aaa,1,0,0);
        v(2'b11,2'b11,16'h0aaa,16'h0bbb,0,0,0,0,0,           2'b10,2'b01,2'b01,0,0,0,32'h33333333,0);
        v(2'b11,2'b11,16'h0aaa,16'h0bbb,0,0,0,0,0,           2'b10,2'b01,2'b01,1,16'h0bbb,1,32'h33333333,0);
        v(2'b11,2'b11,16'h0aaa,16'h0bbb,0,1,1,1,32'h44444444, 2'b10,2'b01,2'b01,1,16'h0bbb,1,32'h33333333,0);
        v(0,0,0,0,0,0,0,0,0,                                 0,0,0,0,0,0,0,0);
        // Reject, consume two cycles later, then a fresh request on lane0
        v(2'b01,2'b01,16'h5555,0,0,0,0,0,0,                 2'b01,0,0,0,0,0,0,0);
        v(2'b01,2'b01,16'h5555,0,0,0,1,0,32'h55555555,      2'b01,0,0,1,16'h5555,1,0,0);
        v(2'b01,2'b01,16'h5555,0,0,0,0,0,0,                 0,2'b01,0,0,0,0,0,0);
        v(2'b01,2'b01,16'h5555,0,2'b01,0,0,0,0,             0,2'b01,0,0,0,0,0,0);
        v(2'b01,2'b01,16'h6666,0,0,0,0,0,0,                 2'b01,0,0,0,0,0,0,0);
        v(2'b01,2'b01,16'h6666,0,0,0,1,1,32'h66666666,      2'b01,0,0,1,16'h6666,1,0,0);
        v(2'b01,2'b01,16'h6666,0,2'b01,0,0,0,0,             0,2'b01,2'b01,0,0,0,32'h66666666,0);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0);
        // Legal lanes are never stalled nor offloaded
        for (int k = 0; k < 3; k++)
            v(2'b11,0,16'h4444,16'h5555,0,0,1,1,32'h1,       0,0,0,0,0,0,0,0);
        // Lane1 alone uses the channel and its own result slot
        v(2'b10,2'b10,0,16'h7777,0,0,0,0,0,                 2'b10,0,0,0,0,0,0,0);
        v(2'b10,2'b10,0,16'h7777,0,0,1,1,32'h77777777,      2'b10,0,0,1,16'h7777,1,0,0);
        v(2'b10,2'b10,0,16'h7777,2'b10,0,0,0,0,             0,2'b10,2'b10,0,0,0,0,32'h77777777);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0);
        // Lane valid drops mid-request; request still completes and result is kept
        v(2'b01,2'b01,16'h8888,0,0,0,0,0,0,                 2'b01,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,1,16'h8888,1,0,0);
        v(0,0,0,0,0,0,1,1,32'h88888888,                     0,0,0,1,16'h8888,1,0,0);
        v(0,0,0,0,2'b01,0,0,0,0,                            0,2'b01,2'b01,0,0,0,32'h88888888,0);
        v(0,0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0);

        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        #1;
        chk("reset_x_valid", 64'(x_valid_o), 64'd0);
        chk("reset_x_instr", 64'(x_instr_o), 64'd0);
        chk("reset_hartid", x_hartid_o, HART);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(lane_done_o), 64'd0);
        chk("reset_result", lane_instr_o, 64'd0);

        for (int n = 0; n < vecs.size(); n++) begin
            cur = n;
            lane_valid_i   = vecs[n].valid;
            lane_illegal_i = vecs[n].ill;
            lane_instr_i   = {vecs[n].i1, vecs[n].i0};
            lane_consume_i = vecs[n].cons;
            flush_i        = vecs[n].flush;
            x_ready_i      = vecs[n].rdy;
            x_accept_i     = vecs[n].acc;
            x_instr_i      = vecs[n].xi;
            #1;
            chk("stall", 64'(lane_stall_o), 64'(vecs[n].e_stall));
            chk("done", 64'(lane_done_o), 64'(vecs[n].e_done));
            chk("accept", 64'(lane_accept_o), 64'(vecs[n].e_acc));
            chk("x_valid", 64'(x_valid_o), 64'(vecs[n].e_xv));
            chk("busy", 64'(busy_o), 64'(vecs[n].e_busy));
            chk("lane0_instr", 64'(lane_instr_o[31:0]), 64'(vecs[n].e_li0));
            chk("lane1_instr", 64'(lane_instr_o[63:32]), 64'(vecs[n].e_li1));
            if (vecs[n].e_xv) begin
                chk("x_instr", 64'(x_instr_o), 64'(vecs[n].e_xio));
                chk("x_hartid", x_hartid_o, HART);
            end
            tick();
        end

        // Asynchronous reset while a request is outstanding
        cur = -2;
        lane_valid_i = 2'b01; lane_illegal_i = 2'b01; lane_instr_i = 32'h0000_0abc;
        lane_consume_i = '0; flush_i = 1'b0; x_ready_i = 1'b0; x_accept_i = 1'b0;
        tick();
        chk("arst_pre_valid", 64'(x_valid_o), 64'd1);
        chk("arst_pre_instr", 64'(x_instr_o), 64'h0abc);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(x_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_instr", 64'(x_instr_o), 64'd0);
        lane_valid_i = '0; lane_illegal_i = '0;
        tick();
        rst_ni = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
